// File: rtl/pong_motion_if.sv
// Signal bundle between the pingpong ball sequencer (slave) and its environment (master):
// the environment drives the control and collision inputs, the sequencer drives ball and score state.
interface pong_motion_if #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int SW = 4
);
  logic          start;
  logic          serve_dir;
  logic          tick;
  logic          collide_l;
  logic          collide_r;
  logic [XW-1:0] ball_x;
  logic [YW-1:0] ball_y;
  logic          vx_neg;
  logic          vy_neg;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          halt;
  logic          game_over;
  logic          winner;

  modport master (
    output start, serve_dir, tick, collide_l, collide_r,
    input  ball_x, ball_y, vx_neg, vy_neg, score_l, score_r,
    input  hit_pulse, miss_pulse, halt, game_over, winner
  );

  modport slave (
    input  start, serve_dir, tick, collide_l, collide_r,
    output ball_x, ball_y, vx_neg, vy_neg, score_l, score_r,
    output hit_pulse, miss_pulse, halt, game_over, winner
  );
endinterface

// File: rtl/pong_motion_ctrl.sv
// Pingpong ball sequencer: steps the ball once per frame tick, resolves walls, paddles and misses,
// and keeps both scores. Define PONG_SPEEDUP_EN to raise the speed every HITS_PER_LEVEL paddle hits.
module pong_motion_ctrl #(
  parameter int XW             = 10,
  parameter int YW             = 9,
  parameter int FIELD_W        = 640,
  parameter int FIELD_H        = 480,
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int SW             = 4,
  parameter int WIN_SCORE      = 11,
  parameter int MAX_SPEED      = 4,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pong_motion_if.slave mif
);

  localparam logic [2:0] S_WAIT    = 3'd0;
  localparam logic [2:0] S_SERVE   = 3'd1;
  localparam logic [2:0] S_MOVE    = 3'd2;
  localparam logic [2:0] S_CALC    = 3'd3;
  localparam logic [2:0] S_COLLIDE = 3'd4;
  localparam logic [2:0] S_UPDATE  = 3'd5;
  localparam logic [2:0] S_POINT   = 3'd6;
  localparam logic [2:0] S_OVER    = 3'd7;

  localparam logic [XW-1:0]      INIT_XV = XW'(INIT_X);
  localparam logic [YW-1:0]      INIT_YV = YW'(INIT_Y);
  localparam logic signed [XW:0] X_ZERO  = '0;
  localparam logic signed [XW:0] X_MAX   = (XW+1)'(FIELD_W - 1);
  localparam logic signed [YW:0] Y_ZERO  = '0;
  localparam logic signed [YW:0] Y_MAX   = (YW+1)'(FIELD_H - 1);
  localparam logic [SW-1:0]      WIN_SC  = SW'(WIN_SCORE);

  logic [2:0]          state_q, state_d;
  logic [XW-1:0]       ball_x_q, ball_x_d;
  logic [YW-1:0]       ball_y_q, ball_y_d;
  logic                vx_neg_q, vx_neg_d;
  logic                vy_neg_q, vy_neg_d;
  logic [SW-1:0]       score_l_q, score_l_d;
  logic [SW-1:0]       score_r_q, score_r_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic                miss_pulse_q, miss_pulse_d;
  logic                winner_q, winner_d;
  logic                hit_q, hit_d;
  logic signed [XW:0]  nx_q, nx_d;
  logic signed [YW:0]  ny_q, ny_d;
  logic signed [XW:0]  step_x, bx_s, nx_fwd, nx_rev;
  logic signed [YW:0]  step_y, by_s, ny_raw;

`ifdef PONG_SPEEDUP_EN
  localparam int SPW = $clog2(MAX_SPEED + 1);
  localparam int HW  = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [SPW-1:0] SPEED_MAX = SPW'(MAX_SPEED);
  localparam logic [HW-1:0]  HITS_LAST = HW'(HITS_PER_LEVEL - 1);

  logic [SPW-1:0] speed_q, speed_d;
  logic [HW-1:0]  hits_q, hits_d;

  assign step_x = (XW+1)'(speed_q);
  assign step_y = (YW+1)'(speed_q);
`else
  assign step_x = (XW+1)'(1);
  assign step_y = (YW+1)'(1);

  // Speed-up parameters stay on the instance interface so both builds share one parameter list.
  if (MAX_SPEED < 1 || HITS_PER_LEVEL < 1) begin : g_speed_cfg_unused
  end
`endif

  assign bx_s   = signed'({1'b0, ball_x_q});
  assign by_s   = signed'({1'b0, ball_y_q});
  assign nx_fwd = vx_neg_q ? bx_s - step_x : bx_s + step_x;
  assign nx_rev = vx_neg_q ? bx_s + step_x : bx_s - step_x;
  assign ny_raw = vy_neg_q ? by_s - step_y : by_s + step_y;

  always_comb begin
    state_d      = state_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    vx_neg_d     = vx_neg_q;
    vy_neg_d     = vy_neg_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    winner_d     = winner_q;
    hit_d        = hit_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
`ifdef PONG_SPEEDUP_EN
    speed_d      = speed_q;
    hits_d       = hits_q;
`endif
    case (state_q)
      S_WAIT, S_OVER: begin
        if (mif.start) begin
          score_l_d = '0;
          score_r_d = '0;
          state_d   = S_SERVE;
        end
      end
      S_SERVE: begin
        ball_x_d = INIT_XV;
        ball_y_d = INIT_YV;
        vx_neg_d = ~mif.serve_dir;
`ifdef PONG_SPEEDUP_EN
        speed_d  = SPW'(1);
        hits_d   = '0;
`endif
        state_d  = S_MOVE;
      end
      S_MOVE: begin
        if (mif.tick) state_d = S_CALC;
      end
      S_CALC: begin
        nx_d  = nx_fwd;
        hit_d = 1'b0;
        if (ny_raw <= Y_ZERO) begin
          ny_d     = Y_ZERO;
          vy_neg_d = ~vy_neg_q;
        end else if (ny_raw >= Y_MAX) begin
          ny_d     = Y_MAX;
          vy_neg_d = ~vy_neg_q;
        end else begin
          ny_d = ny_raw;
        end
        state_d = S_COLLIDE;
      end
      S_COLLIDE: begin
        // Only a paddle facing the ball's direction of travel reflects it.
        if ((mif.collide_l && vx_neg_q) || (mif.collide_r && !vx_neg_q)) begin
          vx_neg_d    = ~vx_neg_q;
          nx_d        = nx_rev;
          hit_d       = 1'b1;
          hit_pulse_d = 1'b1;
`ifdef PONG_SPEEDUP_EN
          if (hits_q == HITS_LAST) begin
            hits_d = '0;
            if (speed_q != SPEED_MAX) speed_d = speed_q + 1'b1;
          end else begin
            hits_d = hits_q + 1'b1;
          end
`endif
        end
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (!hit_q && nx_q <= X_ZERO) begin
          if (score_r_q != WIN_SC) score_r_d = score_r_q + 1'b1;
          miss_pulse_d = 1'b1;
          state_d      = S_POINT;
        end else if (!hit_q && nx_q >= X_MAX) begin
          if (score_l_q != WIN_SC) score_l_d = score_l_q + 1'b1;
          miss_pulse_d = 1'b1;
          state_d      = S_POINT;
        end else begin
          ball_x_d = nx_q[XW-1:0];
          ball_y_d = ny_q[YW-1:0];
          state_d  = S_MOVE;
        end
      end
      S_POINT: begin
        if (score_l_q == WIN_SC) begin
          winner_d = 1'b0;
          state_d  = S_OVER;
        end else if (score_r_q == WIN_SC) begin
          winner_d = 1'b1;
          state_d  = S_OVER;
        end else if (mif.start) begin
          state_d = S_SERVE;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      ball_x_q     <= INIT_XV;
      ball_y_q     <= INIT_YV;
      vx_neg_q     <= 1'b0;
      vy_neg_q     <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      winner_q     <= 1'b0;
      hit_q        <= 1'b0;
      nx_q         <= '0;
      ny_q         <= '0;
`ifdef PONG_SPEEDUP_EN
      speed_q      <= SPW'(1);
      hits_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      vx_neg_q     <= vx_neg_d;
      vy_neg_q     <= vy_neg_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      winner_q     <= winner_d;
      hit_q        <= hit_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
`ifdef PONG_SPEEDUP_EN
      speed_q      <= speed_d;
      hits_q       <= hits_d;
`endif
    end
  end

  assign mif.ball_x     = ball_x_q;
  assign mif.ball_y     = ball_y_q;
  assign mif.vx_neg     = vx_neg_q;
  assign mif.vy_neg     = vy_neg_q;
  assign mif.score_l    = score_l_q;
  assign mif.score_r    = score_r_q;
  assign mif.hit_pulse  = hit_pulse_q;
  assign mif.miss_pulse = miss_pulse_q;
  assign mif.winner     = winner_q;
  assign mif.game_over  = (state_q == S_OVER);
  assign mif.halt       = (state_q == S_WAIT) || (state_q == S_POINT) || (state_q == S_OVER);

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Scoreboard bench for pong_motion_ctrl: stimulus pushes expected ball events, a monitor
// pops and compares whenever the ball moves or a point is awarded; directed checks cover boundaries.
module tb_pong_motion_ctrl;

  typedef struct {
    int x; int y; int vxn; int vyn; int hit; int miss; int sl; int sr; int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_motion_if #(.XW(10), .YW(9), .SW(4)) pif ();

  pong_motion_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (pif)
  );

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: 0 wait, 1 in play, 2 point, 3 game over
  int mx = 320, my = 240, mvxn = 0, mvyn = 0, msl = 0, msr = 0, msp = 1, mhits = 0, mstate = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: any ball move or miss pulse is one transaction.
  int  px = 320, py = 240, hit_seen = 0;
  ev_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      px = 320; py = 240; hit_seen = 0;
    end else begin
      if (pif.hit_pulse) hit_seen = 1;
      if (int'(pif.ball_x) != px || int'(pif.ball_y) != py || pif.miss_pulse) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got x=%0d y=%0d miss=%0d, expected no event",
                   pif.ball_x, pif.ball_y, pif.miss_pulse);
        end else begin
          e = sb_q.pop_front();
          if (e.x != int'(pif.ball_x) || e.y != int'(pif.ball_y) || e.vxn != int'(pif.vx_neg) ||
              e.vyn != int'(pif.vy_neg) || e.hit != hit_seen || e.miss != int'(pif.miss_pulse) ||
              e.sl != int'(pif.score_l) || e.sr != int'(pif.score_r) || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: got x=%0d y=%0d vxn=%0d vyn=%0d hit=%0d miss=%0d sl=%0d sr=%0d cyc=%0d, expected x=%0d y=%0d vxn=%0d vyn=%0d hit=%0d miss=%0d sl=%0d sr=%0d cyc=%0d",
                     pif.ball_x, pif.ball_y, pif.vx_neg, pif.vy_neg, hit_seen, pif.miss_pulse,
                     pif.score_l, pif.score_r, cyc,
                     e.x, e.y, e.vxn, e.vyn, e.hit, e.miss, e.sl, e.sr, e.cyc);
          end else begin
            $display("event x=%0d y=%0d vxn=%0d vyn=%0d hit=%0d miss=%0d sl=%0d sr=%0d cyc=%0d",
                     e.x, e.y, e.vxn, e.vyn, e.hit, e.miss, e.sl, e.sr, e.cyc);
          end
        end
        hit_seen = 0;
      end
      px = int'(pif.ball_x);
      py = int'(pif.ball_y);
    end
  end

  task automatic do_tick(input int cl, input int cr, input int dbl);
    int  hit, nx, ny;
    ev_t ev;
    @(posedge clk); #1;
    pif.tick      = 1'b1;
    pif.collide_l = cl[0];
    pif.collide_r = cr[0];
    if (mstate == 1) begin
      hit = ((cl != 0) && mvxn == 1) || ((cr != 0) && mvxn == 0);
      if (hit != 0) mvxn = 1 - mvxn;
      ny = my + (mvyn != 0 ? -msp : msp);
      if (ny <= 0) begin
        ny = 0; mvyn = 1 - mvyn;
      end else if (ny >= 479) begin
        ny = 479; mvyn = 1 - mvyn;
      end
      nx = mx + (mvxn != 0 ? -msp : msp);
      ev.miss = 0;
      if (hit == 0 && nx <= 0) begin
        if (msr < 11) msr++;
        ev.miss = 1; mstate = 2;
      end else if (hit == 0 && nx >= 639) begin
        if (msl < 11) msl++;
        ev.miss = 1; mstate = 2;
      end else begin
        mx = nx; my = ny;
      end
`ifdef PONG_SPEEDUP_EN
      if (hit != 0) begin
        mhits++;
        if (mhits == 4) begin
          mhits = 0;
          if (msp < 4) msp++;
        end
      end
`endif
      ev.x = mx; ev.y = my; ev.vxn = mvxn; ev.vyn = mvyn; ev.hit = hit;
      ev.sl = msl; ev.sr = msr; ev.cyc = cyc + 4;
      sb_q.push_back(ev);
      if (msl == 11 || msr == 11) mstate = 3;
    end
    @(posedge clk); #1;
    pif.tick = dbl[0];
    @(posedge clk); #1;
    pif.tick = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    pif.collide_l = 1'b0;
    pif.collide_r = 1'b0;
  endtask

  task automatic do_start(input int dir);
    ev_t ev;
    int  changed;
    @(posedge clk); #1;
    pif.start     = 1'b1;
    pif.serve_dir = dir[0];
    if (mstate != 1) begin
      if (mstate == 0 || mstate == 3) begin
        msl = 0; msr = 0;
      end
      changed = (mx != 320 || my != 240) ? 1 : 0;
      mx = 320; my = 240; mvxn = 1 - dir; msp = 1; mhits = 0; mstate = 1;
      if (changed != 0) begin
        ev.x = mx; ev.y = my; ev.vxn = mvxn; ev.vyn = mvyn; ev.hit = 0; ev.miss = 0;
        ev.sl = msl; ev.sr = msr; ev.cyc = cyc + 2;
        sb_q.push_back(ev);
      end
    end
    @(posedge clk); #1;
    pif.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, prev, diff, exp_step, hold_x;
    pif.start = 1'b0; pif.serve_dir = 1'b0; pif.tick = 1'b0;
    pif.collide_l = 1'b0; pif.collide_r = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ball_x", int'(pif.ball_x), 320);
    chk("rst_ball_y", int'(pif.ball_y), 240);
    chk("rst_vx_neg", int'(pif.vx_neg), 0);
    chk("rst_vy_neg", int'(pif.vy_neg), 0);
    chk("rst_scores", int'({pif.score_l, pif.score_r}), 0);
    chk("rst_halt", int'(pif.halt), 1);
    chk("rst_game_over", int'(pif.game_over), 0);
    chk("rst_pulses", int'({pif.hit_pulse, pif.miss_pulse, pif.winner}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_start(1);
    @(negedge clk);
    chk("serve_halt", int'(pif.halt), 0);
    chk("serve_vx_neg", int'(pif.vx_neg), 0);

    repeat (5) do_tick(0, 0, 0);
    @(negedge clk);
    chk("five_ticks_x", int'(pif.ball_x), 325);
    chk("five_ticks_y", int'(pif.ball_y), 245);

    do_tick(0, 0, 1);
    @(negedge clk);
    chk("extra_tick_dropped_x", int'(pif.ball_x), 326);

    g = 0;
    while (!(my == 478 && mvxn == 0 && mvyn == 0) && g < 1000) begin
      do_tick(0, 0, 0); g++;
    end
    do_tick(0, 0, 0);
    @(negedge clk);
    chk("bottom_clamp_y", int'(pif.ball_y), 479);
    chk("bottom_flip_vy", int'(pif.vy_neg), 1);
    do_tick(0, 0, 0);
    @(negedge clk);
    chk("bottom_rebound_y", int'(pif.ball_y), 478);

    do_tick(0, 1, 0);
    @(negedge clk);
    chk("right_paddle_vx_neg", int'(pif.vx_neg), 1);

    while (!(mx == 1 && mvxn == 1) && g < 3000) begin
      do_tick(0, 0, 0); g++;
    end
    do_tick(1, 0, 0);
    @(negedge clk);
    chk("left_hit_x", int'(pif.ball_x), 2);
    chk("left_hit_vx_neg", int'(pif.vx_neg), 0);
    chk("left_hit_score_r", int'(pif.score_r), 0);
    do_tick(0, 1, 0);
    do_tick(0, 0, 0);
    @(negedge clk);
    chk("left_miss_score_r", int'(pif.score_r), 1);
    chk("left_miss_halt", int'(pif.halt), 1);
    do_start(1);
    @(negedge clk);
    chk("reserve_x", int'(pif.ball_x), 320);
    chk("reserve_y", int'(pif.ball_y), 240);

    prev = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) prev = int'(pif.ball_x);
      do_tick(i % 2, 1 - (i % 2), 0);
    end
    @(negedge clk);
    diff = int'(pif.ball_x) - prev;
    if (diff < 0) diff = -diff;
`ifdef PONG_SPEEDUP_EN
    exp_step = 4;
`else
    exp_step = 1;
`endif
    chk("step_after_20_hits", diff, exp_step);

    while (mstate != 3 && g < 20000) begin
      if (mstate == 2) do_start(1);
      do_tick(0, 0, 0); g++;
      if (mstate == 2 && msl == 10) begin
        @(negedge clk);
        chk("score_l_ten", int'(pif.score_l), 10);
        chk("no_game_over_at_ten", int'(pif.game_over), 0);
      end
    end
    if (g >= 20000) begin
      n_cmp++; n_err++;
      $display("FAIL rally_bound: got %0d ticks, expected fewer than 20000", g);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_score_l", int'(pif.score_l), 11);
    chk("final_score_r", int'(pif.score_r), 1);
    chk("game_over", int'(pif.game_over), 1);
    chk("winner_left", int'(pif.winner), 0);
    hold_x = int'(pif.ball_x);
    repeat (3) do_tick(1, 1, 0);
    @(negedge clk);
    chk("over_hold_x", int'(pif.ball_x), hold_x);
    chk("over_hold_score_l", int'(pif.score_l), 11);
    chk("over_hold_game_over", int'(pif.game_over), 1);

    do_start(0);
    @(negedge clk);
    chk("restart_scores", int'({pif.score_l, pif.score_r}), 0);
    chk("restart_game_over", int'(pif.game_over), 0);
    chk("restart_vx_neg", int'(pif.vx_neg), 1);
    do_tick(0, 0, 0);
    do_tick(0, 0, 0);
    @(negedge clk);
    chk("restart_two_ticks_x", int'(pif.ball_x), 318);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pong_motion_ctrl.md
Name: pong_motion_ctrl

Overview:
- Parametrised ball-motion sequencer for the pingpong game. Owns the ball position and velocity registers itself and steps them once per frame tick.
- Resolves wall bounces, left/right paddle hits and misses, and keeps per-player scores up to a winning score.
- Sits between the paddle/collision comparators and the VGA renderer; the renderer reads ball_x/ball_y and the score outputs.

Parameters:
- XW, 10, width of the x coordinate
- YW, 9, width of the y coordinate
- FIELD_W, 640, field width in pixels; valid x is 0..FIELD_W-1
- FIELD_H, 480, field height in pixels; valid y is 0..FIELD_H-1
- INIT_X, 320, serve x position
- INIT_Y, 240, serve y position
- SW, 4, score counter width
- WIN_SCORE, 11, points needed to win a game
- MAX_SPEED, 4, maximum speed in pixels per tick (used only with the optional feature)
- HITS_PER_LEVEL, 4, paddle hits per speed step (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a new game (from WAIT_GAME) or the next serve (from POINT)
- serve_dir  in  1  sampled in SERVE; 0 = ball leaves toward the left, 1 = toward the right
- tick  in  1  one-cycle frame step pulse
- collide_l  in  1  left paddle overlaps the current ball position
- collide_r  in  1  right paddle overlaps the current ball position
- ball_x  out  XW  current ball x
- ball_y  out  YW  current ball y
- vx_neg  out  1  current x direction (1 = moving left)
- vy_neg  out  1  current y direction (1 = moving up)
- score_l  out  SW  left player score
- score_r  out  SW  right player score
- hit_pulse  out  1  one-cycle pulse on a paddle reflection
- miss_pulse  out  1  one-cycle pulse when a point is awarded
- halt  out  1  high whenever the ball is not in play
- game_over  out  1  high in GAME_OVER
- winner  out  1  valid while game_over; 0 = left, 1 = right

Behaviour:
- Reset (asynchronous, while rst_n low):
  - state = WAIT_GAME; ball_x = INIT_X; ball_y = INIT_Y.
  - vx_neg = 0, vy_neg = 0, scores = 0, speed = 1, hit counter = 0.
  - All pulse outputs 0; halt = 1; game_over = 0; winner = 0.
  - Reset asserted mid-rally discards the rally with no point awarded.
- States: WAIT_GAME, SERVE, MOVE, CALC, COLLIDE, UPDATE, POINT, GAME_OVER.
- WAIT_GAME: start -> SERVE, scores cleared.
- SERVE (1 cycle):
  - Position set to INIT_X, INIT_Y.
  - vx_neg = ~serve_dir; vy_neg keeps its last value.
  - Speed = 1, hit counter = 0.
  - Go to MOVE.
- MOVE: tick -> CALC; otherwise stay. Only MOVE accepts tick; a tick in any other state is dropped.
- CALC (1 cycle):
  - nx = ball_x ± speed and ny = ball_y ± speed, computed at XW+1 / YW+1 signed width.
  - If ny <= 0: clamp ny to 0 and flip vy. If ny >= FIELD_H-1: clamp ny to FIELD_H-1 and flip vy.
- COLLIDE (1 cycle):
  - collide_l with vx_neg = 1 -> vx_neg = 0, hit_pulse.
  - collide_r with vx_neg = 0 -> vx_neg = 1, hit_pulse.
  - A collide against the current direction of travel is ignored.
  - After a reflection, nx is recomputed from ball_x in the new direction.
  - A wall bounce and a paddle hit in the same step both apply.
- UPDATE (1 cycle):
  - nx <= 0 with no hit: score_r++, miss_pulse, go to POINT.
  - nx >= FIELD_W-1 with no hit: score_l++, miss_pulse, go to POINT.
  - Otherwise register nx/ny into ball_x/ball_y and return to MOVE.
  - Latency from tick to updated position: 3 cycles.
- POINT:
  - A score equal to WIN_SCORE -> GAME_OVER; winner = the player who reached it.
  - Otherwise start -> SERVE.
- GAME_OVER: holds scores and winner; start -> WAIT_GAME behaviour, i.e. scores cleared, then SERVE.
- halt = 1 in WAIT_GAME, POINT and GAME_OVER; 0 otherwise.
- start outside WAIT_GAME/POINT/GAME_OVER is ignored.
- Scores never exceed WIN_SCORE and never wrap.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined:
  - Every HITS_PER_LEVEL paddle hits, speed increments by 1, saturating at MAX_SPEED.
  - The hit counter resets at each step and at SERVE.
  - Edge and wall clamps use the larger step size.
- Undefined:
  - Speed is constant 1; the hit counter and MAX_SPEED logic are absent.
  - HITS_PER_LEVEL and MAX_SPEED are unused.

Test Plan:
- Reset, start, serve_dir = 1, 5 ticks, no collide -> ball_x = 325, ball_y = 245 or 235 per vy, halt = 0, each update 3 cycles after its tick.
- Ball at y = 479 moving down, tick -> ball_y = 479 and vy_neg = 1; the next tick gives ball_y = 478.
- Ball at x = 1 moving left, collide_l = 1 in COLLIDE -> hit_pulse, vx_neg = 0, ball_x = 2, no point awarded.
- Ball at x = 1 moving left, no collide -> miss_pulse, score_r = 1, halt = 1; start -> ball at (320, 240).
- score_l = 10, right-edge miss -> score_l = 11, game_over = 1, winner = 0; further ticks and collides do not change state.
- With PONG_SPEEDUP_EN, 4 hits -> speed 2; 16 hits -> speed 4, and it stays 4 at 20 hits. Without the macro, 20 hits -> per-tick displacement remains 1.
